// File: rtl/datapath_pkg.sv
// Shared constants for the 5-stage datapath: opcodes, functs, ALU controls,
// memory geometry and the power-on contents of both memories.
package datapath_pkg;

   localparam int unsigned MEM_DEPTH = 64;
   localparam int unsigned MEM_AW    = 6;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR
   } alu_ctrl_e;

   function automatic logic [31:0] imem_word(input logic [MEM_AW-1:0] idx);
      case (idx)
         6'd0:    imem_word = 32'h8C22_0000; // lw  $2, 0($1)
         6'd1:    imem_word = 32'h8C23_0004; // lw  $3, 4($1)
         6'd2:    imem_word = 32'h8C24_0008; // lw  $4, 8($1)
         6'd3:    imem_word = 32'h8C25_000C; // lw  $5,12($1)
         6'd4:    imem_word = 32'h0043_3020; // add $6,$2,$3
         default: imem_word = '0;
      endcase
   endfunction

   function automatic logic [31:0] dmem_init(input int unsigned idx);
      case (idx)
         0:       dmem_init = 32'hA000_00AA;
         1:       dmem_init = 32'h1000_0011;
         2:       dmem_init = 32'h2000_0022;
         3:       dmem_init = 32'h3000_0033;
         default: dmem_init = '0;
      endcase
   endfunction

endpackage

// File: rtl/datapath_regfile.sv
// 32x32 register file: two combinational read ports, one write port that
// commits on the falling clock edge so ID sees WB data in the same cycle.
module regfile
   import datapath_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [4:0]  i_ra,
   input  logic [4:0]  i_rb,
   output logic [31:0] o_qa,
   output logic [31:0] o_qb,
   input  logic        i_we,
   input  logic [4:0]  i_wn,
   input  logic [31:0] i_d
);

   logic [31:0] r_regs [32];

   always_ff @(negedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (i_we && (i_wn != 5'd0)) begin
         r_regs[i_wn] <= i_d;
      end
   end

   assign o_qa = (i_ra == 5'd0) ? '0 : r_regs[i_ra];
   assign o_qb = (i_rb == 5'd0) ? '0 : r_regs[i_rb];

endmodule

// File: rtl/datapath.sv
// Five-stage IF/ID/EXE/MEM/WB pipeline with fixed program ROM and data RAM;
// no forwarding, stalls or control flow.
module datapath
   import datapath_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [31:0] qa,
   output logic [31:0] qb,
   output logic        wwreg,
   output logic        wm2reg,
   output logic [4:0]  wdestReg,
   output logic [31:0] wr,
   output logic [31:0] wdo,
   output logic [31:0] wbData
);

   // PC kept as a word index; byte PC = {r_pcw, 2'b00}, wrapping every 256 bytes.
   logic [MEM_AW-1:0] r_pcw;
   logic [31:0]       r_ir;

   logic        r_ewreg, r_em2reg, r_ewmem, r_ealuimm;
   alu_ctrl_e   r_ealuc;
   logic [4:0]  r_edest;
   logic [31:0] r_eqa, r_eqb, r_eimm;

   logic        r_mwreg, r_mm2reg, r_mwmem;
   logic [4:0]  r_mdest;
   logic [31:0] r_mr, r_mqb;

   logic        r_wwreg, r_wm2reg;
   logic [4:0]  r_wdest;
   logic [31:0] r_wr, r_wdo;

   logic [31:0] r_dmem [MEM_DEPTH];

   logic [5:0]  w_op, w_fn;
   logic [4:0]  w_rd;
   logic        w_wreg, w_m2reg, w_wmem, w_aluimm, w_regrt;
   alu_ctrl_e   w_aluc;
   logic [31:0] w_imm, w_qa, w_qb, w_alub, w_alur, w_mdo;
   logic        w_unused;

   // IF
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcw <= '0;
         r_ir  <= '0;
      end else begin
         r_pcw <= r_pcw + 1'b1;
         r_ir  <= imem_word(r_pcw);
      end
   end

   // ID
   assign w_op  = r_ir[31:26];
   assign w_fn  = r_ir[5:0];
   assign w_rd  = r_ir[15:11];
   assign w_imm = {{16{r_ir[15]}}, r_ir[15:0]};
   assign rs    = r_ir[25:21];
   assign rt    = r_ir[20:16];

   always_comb begin
      w_wreg   = 1'b0;
      w_m2reg  = 1'b0;
      w_wmem   = 1'b0;
      w_aluimm = 1'b0;
      w_regrt  = 1'b0;
      w_aluc   = ALU_ADD;
      case (w_op)
         OP_RTYPE: begin
            w_wreg = 1'b1;
            case (w_fn)
               FN_ADD:  w_aluc = ALU_ADD;
               FN_SUB:  w_aluc = ALU_SUB;
               FN_AND:  w_aluc = ALU_AND;
               FN_OR:   w_aluc = ALU_OR;
               FN_XOR:  w_aluc = ALU_XOR;
               default: w_wreg = 1'b0;
            endcase
         end
         OP_ADDI: begin
            w_wreg = 1'b1; w_aluimm = 1'b1; w_regrt = 1'b1;
         end
         OP_LW: begin
            w_wreg = 1'b1; w_m2reg = 1'b1; w_aluimm = 1'b1; w_regrt = 1'b1;
         end
         OP_SW: begin
            w_wmem = 1'b1; w_aluimm = 1'b1;
         end
         default: ;
      endcase
   end

   regfile u_regfile (
      .i_clk (clk),
      .i_rst (rst),
      .i_ra  (rs),
      .i_rb  (rt),
      .o_qa  (w_qa),
      .o_qb  (w_qb),
      .i_we  (r_wwreg),
      .i_wn  (r_wdest),
      .i_d   (wbData)
   );

   assign qa = w_qa;
   assign qb = w_qb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ewreg   <= 1'b0;
         r_em2reg  <= 1'b0;
         r_ewmem   <= 1'b0;
         r_ealuimm <= 1'b0;
         r_ealuc   <= ALU_ADD;
         r_edest   <= '0;
         r_eqa     <= '0;
         r_eqb     <= '0;
         r_eimm    <= '0;
      end else begin
         r_ewreg   <= w_wreg;
         r_em2reg  <= w_m2reg;
         r_ewmem   <= w_wmem;
         r_ealuimm <= w_aluimm;
         r_ealuc   <= w_aluc;
         r_edest   <= w_regrt ? rt : w_rd;
         r_eqa     <= w_qa;
         r_eqb     <= w_qb;
         r_eimm    <= w_imm;
      end
   end

   // EXE
   assign w_alub = r_ealuimm ? r_eimm : r_eqb;

   always_comb begin
      w_alur = '0;
      case (r_ealuc)
         ALU_ADD: w_alur = r_eqa + w_alub;
         ALU_SUB: w_alur = r_eqa - w_alub;
         ALU_AND: w_alur = r_eqa & w_alub;
         ALU_OR:  w_alur = r_eqa | w_alub;
         ALU_XOR: w_alur = r_eqa ^ w_alub;
         default: w_alur = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mwreg  <= 1'b0;
         r_mm2reg <= 1'b0;
         r_mwmem  <= 1'b0;
         r_mdest  <= '0;
         r_mr     <= '0;
         r_mqb    <= '0;
      end else begin
         r_mwreg  <= r_ewreg;
         r_mm2reg <= r_em2reg;
         r_mwmem  <= r_ewmem;
         r_mdest  <= r_edest;
         r_mr     <= w_alur;
         r_mqb    <= r_eqb;
      end
   end

   // MEM: RAM reloads its initial image on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) r_dmem[i] <= dmem_init(i);
      end else if (r_mwmem) begin
         r_dmem[r_mr[7:2]] <= r_mqb;
      end
   end

   assign w_mdo = r_dmem[r_mr[7:2]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wwreg  <= 1'b0;
         r_wm2reg <= 1'b0;
         r_wdest  <= '0;
         r_wr     <= '0;
         r_wdo    <= '0;
      end else begin
         r_wwreg  <= r_mwreg;
         r_wm2reg <= r_mm2reg;
         r_wdest  <= r_mdest;
         r_wr     <= r_mr;
         r_wdo    <= w_mdo;
      end
   end

   // WB
   assign wwreg    = r_wwreg;
   assign wm2reg   = r_wm2reg;
   assign wdestReg = r_wdest;
   assign wr       = r_wr;
   assign wdo      = r_wdo;
   assign wbData   = r_wm2reg ? r_wdo : r_wr;

   assign w_unused = ^{r_ir[10:6], r_mr[31:8], r_mr[1:0]};

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: scoreboard of expected MEM/WB contents
// per clock edge, plus ID-stage register-read and reset checks.
module tb_datapath;

   logic        clk;
   logic        rst;
   logic [4:0]  rs, rt;
   logic [31:0] qa, qb;
   logic        wwreg, wm2reg;
   logic [4:0]  wdestReg;
   logic [31:0] wr, wdo, wbData;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // kind: 0 = only control bits meaningful, 1 = full incl. wdo, 2 = full without wdo
   typedef struct {
      int unsigned kind;
      logic        wreg;
      logic        m2reg;
      logic [4:0]  dest;
      logic [31:0] r;
      logic [31:0] mdo;
      logic [31:0] wb;
   } wb_exp_t;

   wb_exp_t     sb[$];
   logic [31:0] dinit [4];

   datapath dut (
      .clk      (clk),
      .rst      (rst),
      .rs       (rs),
      .rt       (rt),
      .qa       (qa),
      .qb       (qb),
      .wwreg    (wwreg),
      .wm2reg   (wm2reg),
      .wdestReg (wdestReg),
      .wr       (wr),
      .wdo      (wdo),
      .wbData   (wbData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_zero_outputs(input string tag);
      total++;
      if ({wwreg, wm2reg, wdestReg, wr, wdo, wbData} !== '0) begin
         bad++;
         $display("FAIL %s: wwreg=%0b wm2reg=%0b dest=%0d wr=%h wdo=%h wb=%h, required all 0",
                  tag, wwreg, wm2reg, wdestReg, wr, wdo, wbData);
      end
      total++;
      if ({rs, rt} !== 10'd0) begin
         bad++;
         $display("FAIL %s_rsrt: rs=%0d rt=%0d, required 0 0", tag, rs, rt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #13;
      check_zero_outputs("reset_held");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero_outputs("reset_release");
   endtask

   task automatic push_program_expectations();
      wb_exp_t e;
      sb.delete();
      for (int i = 1; i <= 10; i++) begin
         e = '{kind: 0, wreg: 1'b0, m2reg: 1'b0, dest: 5'd0, r: '0, mdo: '0, wb: '0};
         if (i >= 4 && i <= 7) begin
            e.kind  = 1;
            e.wreg  = 1'b1;
            e.m2reg = 1'b1;
            e.dest  = 5'(i - 2);
            e.r     = 32'((i - 4) * 4);
            e.mdo   = dinit[i-4];
            e.wb    = dinit[i-4];
         end else if (i == 8) begin
            e.kind = 2;
            e.wreg = 1'b1;
            e.dest = 5'd6;
            e.r    = dinit[0] + dinit[1];
            e.wb   = dinit[0] + dinit[1];
         end
         sb.push_back(e);
      end
   endtask

   task automatic compare_wb(input int edge_no);
      wb_exp_t e;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL sb_empty: edge %0d has no expectation", edge_no);
         return;
      end
      e = sb.pop_front();
      total++;
      if (wwreg !== e.wreg || wm2reg !== e.m2reg) begin
         bad++;
         $display("FAIL wb_ctrl edge%0d: wwreg=%0b wm2reg=%0b, required %0b %0b",
                  edge_no, wwreg, wm2reg, e.wreg, e.m2reg);
      end
      if (e.kind != 0) begin
         total++;
         if (wdestReg !== e.dest || wr !== e.r || wbData !== e.wb) begin
            bad++;
            $display("FAIL wb_data edge%0d: dest=%0d wr=%h wb=%h, required %0d %h %h",
                     edge_no, wdestReg, wr, wbData, e.dest, e.r, e.wb);
         end
      end
      if (e.kind == 1) begin
         total++;
         if (wdo !== e.mdo) begin
            bad++;
            $display("FAIL wb_wdo edge%0d: wdo=%h, required %h", edge_no, wdo, e.mdo);
         end
      end
   endtask

   // Runs from just after reset release for n_edges rising edges.
   task automatic test_program(input int n_edges);
      push_program_expectations();
      for (int i = 1; i <= n_edges; i++) begin
         @(posedge clk);
         #1;
         compare_wb(i);
         if (i == 1) begin
            total++;
            if (rs !== 5'd1 || rt !== 5'd2) begin
               bad++;
               $display("FAIL id_edge1: rs=%0d rt=%0d, required 1 2", rs, rt);
            end
         end
         if (i == 5) begin
            total++;
            if (rs !== 5'd2 || rt !== 5'd3 || qb !== 32'd0) begin
               bad++;
               $display("FAIL id_edge5_pre: rs=%0d rt=%0d qb=%h, required 2 3 0", rs, rt, qb);
            end
            @(negedge clk);
            #1;
            total++;
            if (qa !== dinit[0] || qb !== dinit[1]) begin
               bad++;
               $display("FAIL id_edge5_post: qa=%h qb=%h, required %h %h", qa, qb, dinit[0], dinit[1]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero_outputs("mid_release");
   endtask

   initial begin
      dinit[0] = 32'hA000_00AA;
      dinit[1] = 32'h1000_0011;
      dinit[2] = 32'h2000_0022;
      dinit[3] = 32'h3000_0033;
      rst = 1'b0;
      test_reset();
      test_program(10);
      test_reset();
      test_program(6);
      test_mid_reset();
      test_program(10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have these ports: clk, input, 1, single clock, rising edge active except register-file write.
REQ-002 SHALL have these ports: rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have these ports: rs, output, 5, IF/ID instruction [25:21].
REQ-004 SHALL have these ports: rt, output, 5, IF/ID instruction [20:16].
REQ-005 SHALL have these ports: qa, output, 32, register-file read data at rs.
REQ-006 SHALL have these ports: qb, output, 32, register-file read data at rt.
REQ-007 SHALL have these ports: wwreg, output, 1, MEM/WB register-write enable.
REQ-008 SHALL have these ports: wm2reg, output, 1, MEM/WB memory-to-register select.
REQ-009 SHALL have these ports: wdestReg, output, 5, MEM/WB destination register.
REQ-010 SHALL have these ports: wr, output, 32, MEM/WB ALU result.
REQ-011 SHALL have these ports: wdo, output, 32, MEM/WB data-memory read data.
REQ-012 SHALL have these ports: wbData, output, 32, write-back value: wdo if wm2reg, else wr.

Function
REQ-013 SHALL be a 5-stage pipeline IF/ID/EXE/MEM/WB; pipeline registers on clk rising edge; no forwarding, stalls, branches or jumps.
REQ-014 IF SHALL: PC += 4 every edge; 64-word instruction ROM indexed by PC[7:2] (wraps every 256 bytes), combinational read.
REQ-015 ID SHALL: combinational decode and register-file read; immediate sign-extended to 32 bits; destination = rt for I-type, rd for R-type.
REQ-016 Supported opcodes: R-type opcode 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor; 0x08 addi; 0x23 lw; 0x2B sw.
REQ-017 Any other opcode/funct, including all-zero word, SHALL be a nop: wreg=0, wmem=0.
REQ-018 EXE ALU SHALL be 32-bit with wrap-around and no overflow trap; B operand = imm for addi/lw/sw, else qb.
REQ-019 MEM SHALL: 64-word data RAM indexed by ALU result [7:2]; combinational read; write on rising edge when wmem.
REQ-020 WB: register file (32x32, two combinational read ports) SHALL write wbData to wdestReg on clk falling edge when wwreg.
REQ-021 A write in cycle N SHALL be readable by ID in the same cycle after the falling edge.
REQ-022 Writes to r0 SHALL be ignored; r0 reads 0.
REQ-023 Latency: instruction at PC=4k SHALL be in IF/ID after rising edge k+1 and in MEM/WB after edge k+4 (edge 1 = first edge after reset release).
REQ-024 Instruction ROM program SHALL be: 0:lw $2,0($1); 4:lw $3,4($1); 8:lw $4,8($1); 12:lw $5,12($1); 16:add $6,$2,$3; remainder 0.
REQ-025 Data RAM initial contents SHALL be: word0=0xA00000AA, word1=0x10000011, word2=0x20000022, word3=0x30000033, rest 0.

Reset
REQ-026 rst SHALL immediately: PC=0; all pipeline registers 0 (all outputs of REQ-007..REQ-011 = 0).
REQ-027 rst SHALL immediately: register file all 0; data RAM reloaded to REQ-025 contents.
REQ-028 Reset asserted mid-program SHALL abort all in-flight instructions; execution restarts at PC=0.

Structure
REQ-029 Shared package SHALL hold opcode/funct constants, ALU-control codes, and memory depth parameter.
REQ-030 One sub-module regfile (2R/1W, falling-edge write, async reset) SHALL be used; all other logic stays in datapath.

Verification
REQ-031 Reset, then release -> all MEM/WB outputs 0, PC 0; after edge 1: rs=1, rt=2.
REQ-032 After edge 4 -> wwreg=1, wm2reg=1, wdestReg=2, wr=0x00000000, wdo=wbData=0xA00000AA.
REQ-033 After edges 5,6,7 -> wdestReg=3,4,5; wbData=0x10000011, 0x20000022, 0x30000033 respectively; wr=4,8,12.
REQ-034 After edge 5, past falling edge -> rs=2, rt=3, qa=0xA00000AA; after cycle-6 falling edge, qb=0x10000011 (same-cycle write-then-read).
REQ-035 After edge 8 -> wwreg=1, wm2reg=0, wdestReg=6, wr=wbData=0xB00000BB; later cycles show nops (wwreg=0).
REQ-036 Assert rst after edge 6 -> outputs 0 immediately; after release, REQ-032 sequence repeats exactly.
